// File: rtl/axil_cmd_frame_parser.sv
// axil_cmd_frame_parser: deframes a host byte stream into AXI-Lite command headers and TX FIFO payload words.
module axil_cmd_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] MAX_LEN        = 16'd256,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] tx_fifo_wr_data,
  output logic        tx_fifo_wr_en,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_flush,
  output logic [43:0] head_reg,
  output logic        head_valid,
  input  logic        head_ready,
  output logic        frame_error,
  output logic [1:0]  err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {HUNT, HDR, LEN, DATA, WAIT_ACK} state_t;
  state_t      state_q;
  logic        up_q;
  logic [1:0]  idx_q;
  logic [23:0] addr_q;
  logic [23:0] acc_q;
  logic [3:0]  op_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [43:0] head_q;
  logic        head_valid_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic        flush_q;
  logic [15:0] len_d;
  logic        len_bad;
  logic        xfer;
  logic        in_frame;
  // up_q keeps in_ready low while reset is asserted even though the FSM sits in HUNT
  assign in_ready        = up_q & (state_q == DATA ? !tx_fifo_full : state_q != WAIT_ACK);
  assign xfer            = in_valid & in_ready;
  assign in_frame        = state_q == HDR || state_q == LEN || state_q == DATA;
  assign len_d           = {len_q[7:0], in_data};
  assign len_bad         = len_d == 16'd0 || len_d > MAX_LEN;
  assign tx_fifo_wr_en   = xfer && state_q == DATA && idx_q == 2'd3;
  assign tx_fifo_wr_data = {acc_q, in_data};
  assign head_reg        = head_q;
  assign head_valid      = head_valid_q;
  assign frame_error     = err_q;
  assign err_code        = err_code_q;
  assign tx_fifo_flush   = flush_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      up_q         <= 1'b0;
      idx_q        <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      op_q         <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      flush_q      <= 1'b0;
    end else begin
      up_q    <= 1'b1;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        HUNT: if (xfer && in_data == SYNC_BYTE) begin
          state_q <= HDR;
          idx_q   <= '0;
          tmo_q   <= '0;
        end
        HDR: if (xfer) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            op_q    <= in_data[3:0];
            idx_q   <= '0;
            state_q <= LEN;
          end else
            addr_q <= {addr_q[15:0], in_data};
        end
        LEN: if (xfer) begin
          len_q <= len_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_q <= '0;
            cnt_q <= '0;
            if (len_bad) begin
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              state_q    <= HUNT;
            end else if (op_q[0])
              state_q <= DATA;
            else begin
              head_q       <= {len_d, addr_q, op_q};
              head_valid_q <= 1'b1;
              state_q      <= WAIT_ACK;
            end
          end
        end
        DATA: if (xfer) begin
          acc_q <= {acc_q[15:0], in_data};
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) begin
              head_q       <= {len_q, addr_q, op_q};
              head_valid_q <= 1'b1;
              state_q      <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: if (head_ready) begin
          head_valid_q <= 1'b0;
          state_q      <= HUNT;
        end
        default: state_q <= HUNT;
      endcase
      // inter-byte watchdog; also runs while DATA is stalled by a full FIFO
      if (in_frame) begin
        if (xfer)
          tmo_q <= '0;
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_q      <= '0;
          err_q      <= 1'b1;
          err_code_q <= 2'd1;
          flush_q    <= state_q == DATA;
          state_q    <= HUNT;
        end else
          tmo_q <= tmo_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axil_cmd_frame_parser.sv
// tb_axil_cmd_frame_parser: directed checks of framing, FIFO pushes, errors, timeout, stalls and reset.
module tb_axil_cmd_frame_parser;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] tx_fifo_wr_data;
  logic        tx_fifo_wr_en;
  logic        tx_fifo_full;
  logic        tx_fifo_flush;
  logic [43:0] head_reg;
  logic        head_valid;
  logic        head_ready;
  logic        frame_error;
  logic [1:0]  err_code;
  int          passed = 0;
  int          total = 0;
  logic [31:0] pushes[$];
  logic [7:0]  seq[$];
  int          cnt;
  axil_cmd_frame_parser dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_fifo_wr_data(tx_fifo_wr_data), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_flush(tx_fifo_flush), .head_reg(head_reg), .head_valid(head_valid), .head_ready(head_ready),
    .frame_error(frame_error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask
  // FIFO model: record every push, and a push must never coincide with full
  always @(negedge clk) if (tx_fifo_wr_en === 1'b1) begin
    chk("no_push_when_full", tx_fifo_full, 0);
    pushes.push_back(tx_fifo_wr_data);
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask
  task automatic ack();
    head_ready = 1'b1;
    @(posedge clk); #1;
    head_ready = 1'b0;
    chk("ack_clears_valid", head_valid, 0);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_fifo_full = 1'b0; head_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_head_valid", head_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_head_reg", head_reg, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_wr_en", tx_fifo_wr_en, 0);
    chk("rst_flush", tx_fifo_flush, 0);
    reset_n = 1'b1;
    // read frame
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00};
    send_seq();
    chk("t1_no_valid_early", head_valid, 0);
    send(8'h01);
    chk("t1_head_valid", head_valid, 1);
    chk("t1_head_reg", head_reg, 44'h0001_001234_0);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_no_push", pushes.size(), 0);
    ack();
    // write frame with two payload words
    seq = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h02,
            8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_seq();
    chk("t2_head_valid", head_valid, 1);
    chk("t2_head_reg", head_reg, 44'h0002_000010_1);
    chk("t2_push_count", pushes.size(), 2);
    if (pushes.size() == 2) begin
      chk("t2_word0", pushes[0], 32'hDEADBEEF);
      chk("t2_word1", pushes[1], 32'hCAFEF00D);
    end
    ack();
    pushes.delete();
    // junk before SYNC, then the read frame again
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h01};
    send_seq();
    chk("t3_junk_head_reg", head_reg, 44'h0001_001234_0);
    chk("t3_junk_valid", head_valid, 1);
    ack();
    // len = 0
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
    send_seq();
    chk("t3_len0_err", frame_error, 1);
    chk("t3_len0_code", err_code, 2);
    chk("t3_len0_noflush", tx_fifo_flush, 0);
    chk("t3_len0_novalid", head_valid, 0);
    @(posedge clk); #1;
    chk("t3_err_pulse", frame_error, 0);
    // len = 257 on a write opcode
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h01, 8'h01, 8'h01};
    send_seq();
    chk("t3_len257_err", frame_error, 1);
    chk("t3_len257_code", err_code, 2);
    chk("t3_len257_hunt", in_ready, 1);
    // len = MAX_LEN accepted on a read
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01, 8'h00};
    send_seq();
    chk("t3_lenmax_err", frame_error, 0);
    chk("t3_lenmax_head", head_reg, 44'h0100_001234_0);
    ack();
    // timeout mid-payload after six bytes
    seq = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h02,
            8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
    send_seq();
    cnt = 0;
    while (frame_error !== 1'b1 && cnt < 1100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("t4_timeout_cycles", cnt, 1000);
    chk("t4_err", frame_error, 1);
    chk("t4_code", err_code, 1);
    chk("t4_flush", tx_fifo_flush, 1);
    chk("t4_one_push", pushes.size(), 1);
    @(posedge clk); #1;
    chk("t4_flush_pulse", tx_fifo_flush, 0);
    pushes.delete();
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h01};
    send_seq();
    chk("t4_resync_head", head_reg, 44'h0001_001234_0);
    ack();
    // FIFO full stall on the last byte of the first word
    seq = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    send_seq();
    in_data = 8'hEF; in_valid = 1'b1; tx_fifo_full = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("t5_stall_ready", in_ready, 0);
    chk("t5_stall_nopush", pushes.size(), 0);
    tx_fifo_full = 1'b0;
    seq = '{8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_seq();
    chk("t5_push_count", pushes.size(), 2);
    if (pushes.size() == 2) begin
      chk("t5_word0", pushes[0], 32'hDEADBEEF);
      chk("t5_word1", pushes[1], 32'hCAFEF00D);
    end
    chk("t5_head_reg", head_reg, 44'h0002_000010_1);
    ack();
    pushes.delete();
    // head_ready withheld
    seq = '{8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h70, 8'h00, 8'h03};
    send_seq();
    repeat (50) @(posedge clk); #1;
    chk("t6_hold_valid", head_valid, 1);
    chk("t6_hold_head", head_reg, 44'h0003_ABCDEF_0);
    chk("t6_hold_ready", in_ready, 0);
    ack();
    chk("t6_back_to_hunt", in_ready, 1);
    // async reset mid-payload
    seq = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD};
    send_seq();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_head_reg", head_reg, 0);
    chk("t6_rst_err", frame_error, 0);
    chk("t6_rst_code", err_code, 0);
    chk("t6_rst_flush", tx_fifo_flush, 0);
    chk("t6_rst_valid", head_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seq = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h01};
    send_seq();
    chk("t6_after_rst_head", head_reg, 44'h0001_001234_0);
    chk("t6_after_rst_nopush", pushes.size(), 0);
    ack();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
